// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop output decoder.
//   ST_IDLE / ST_ACTIVE / ST_STALL : FSM state encodings that appear on the
//                                    tff_decoder 'state' output.
package tff_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;

endpackage

// File: rtl/tff_decoder_toggle_detect.sv
// Edge/toggle detection front end of tff_decoder.
// The previous q_in level is kept in a delay flop. A toggle is recognised
// when q_in differs from that level. Detection is held off until one clock
// edge after reset, so the reset value of the delay flop cannot cause a
// false toggle.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous reset, active low
//   q_in   : toggling level from the T flip-flop
//   en     : decode enable (the delay flop keeps tracking while en=0)
//   clr    : suppresses the output pulses of a toggle seen on the same edge
//   det    : combinational, 1 when the current edge carries a toggle
//   t_out  : registered one-cycle pulse per detected toggle
//   rise   : t_out qualified with new q_in = 1
//   fall   : t_out qualified with new q_in = 0
module toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  input  logic en,
  input  logic clr,
  output logic det,
  output logic t_out,
  output logic rise,
  output logic fall
);

  logic q_d_q, q_d_d;
  logic primed_q, primed_d;
  logic t_q, t_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    det      = en & primed_q & (q_in ^ q_d_q);
    // The delay flop and primed are left alone by clr, so the edge after a
    // clear still compares against the true previous level.
    q_d_d    = q_in;
    primed_d = 1'b1;
    t_d      = det & ~clr;
    rise_d   = t_d & q_in;
    fall_d   = t_d & ~q_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_d_q    <= 1'b0;
      primed_q <= 1'b0;
      t_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      q_d_q    <= q_d_d;
      primed_q <= primed_d;
      t_q      <= t_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign t_out = t_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/tff_decoder.sv
// Decoder for the output pair of a T flip-flop.
// It recovers the T input as a pulse per toggle, counts toggles with a
// saturating counter, flags q/qb disagreement, and tracks activity with a
// small FSM. The FSM stalls after TIMEOUT idle enabled cycles.
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous reset, active low; overrides clr and en
//   q_in    : toggling level, synchronous to clk
//   qb_in   : complement of q_in
//   en      : decode enable
//   clr     : synchronous clear of counter, flags, timer and state
//   t_out   : one-cycle pulse per detected toggle
//   rise    : pulse for a 0->1 toggle
//   fall    : pulse for a 1->0 toggle
//   evt_cnt : saturating toggle count
//   sat     : evt_cnt is all-ones
//   err     : sticky, q_in equalled qb_in on some edge
//   state   : FSM state (IDLE=0, ACTIVE=1, STALL=2)
module tff_decoder
  import tff_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             qb_in,
  input  logic             en,
  input  logic             clr,
  output logic             t_out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             sat,
  output logic             err,
  output logic [1:0]       state
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             det;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       state_q, state_d;

  toggle_detect u_toggle_detect (
    .clk   (clk),
    .rst   (rst),
    .q_in  (q_in),
    .en    (en),
    .clr   (clr),
    .det   (det),
    .t_out (t_out),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    err_d   = err_q | (q_in == qb_in);
    tmr_d   = tmr_q;
    state_d = state_q;

    if (clr) begin
      // clr beats both a simultaneous toggle and a q/qb fault on this edge.
      cnt_d   = '0;
      sat_d   = 1'b0;
      err_d   = 1'b0;
      tmr_d   = '0;
      state_d = ST_IDLE;
    end else begin
      if (det && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      sat_d = (cnt_d == CNT_MAX);

      case (state_q)
        ST_IDLE: begin
          if (det) begin
            state_d = ST_ACTIVE;
            tmr_d   = '0;
          end
        end
        ST_ACTIVE: begin
          if (det) begin
            tmr_d = '0;
          end else if (en) begin
            // The timer counts idle enabled edges. The edge that finds it
            // at TIMEOUT-1 is the TIMEOUT-th idle edge.
            if (tmr_q == TMR_LAST) begin
              state_d = ST_STALL;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + TMR_ONE;
            end
          end
        end
        ST_STALL: begin
          if (det) begin
            state_d = ST_ACTIVE;
            tmr_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
    end
  end

  assign evt_cnt = cnt_q;
  assign sat     = sat_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_tff_decoder.sv
// Bench for tff_decoder. Two instances share the same inputs: one with
// CNT_W=8 and one with CNT_W=2, which exercises saturation.
// Inputs change on the falling edge. Outputs are read on the falling edge.
// Every expected toggle pulse is queued as {t_out, rise, fall, evt_cnt}. A
// monitor pops one entry each time the DUT pulses.
module tb_tff_decoder;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst, q_in, qb_in, en, clr;
  logic       t_out, rise, fall, sat, err;
  logic [7:0] evt_cnt;
  logic [1:0] state;
  logic       b_t_out, b_rise, b_fall, b_sat, b_err;
  logic [1:0] b_cnt;
  logic [1:0] b_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  tff_decoder #(.CNT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .qb_in(qb_in), .en(en), .clr(clr),
    .t_out(t_out), .rise(rise), .fall(fall), .evt_cnt(evt_cnt),
    .sat(sat), .err(err), .state(state)
  );

  tff_decoder #(.CNT_W(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .qb_in(qb_in), .en(en), .clr(clr),
    .t_out(b_t_out), .rise(b_rise), .fall(b_fall), .evt_cnt(b_cnt),
    .sat(b_sat), .err(b_err), .state(b_state)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs at the current falling edge; return at the next falling edge.
  task automatic step(input logic q, input logic e, input logic c);
    q_in  = q;
    qb_in = ~q;
    en    = e;
    clr   = c;
    @(negedge clk);
  endtask

  task automatic push(input logic r, input logic [7:0] cnt);
    exp_q.push_back({1'b1, r, ~r, cnt});
  endtask

  // Monitor: each pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (t_out | rise | fall) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse: got t/r/f=%b%b%b cnt=%0d expected no pulse",
                 t_out, rise, fall, evt_cnt);
      end else begin
        e = exp_q.pop_front();
        if ({t_out, rise, fall, evt_cnt} !== e) begin
          bad++;
          $display("FAIL pulse: got t/r/f=%b%b%b cnt=%0d expected t/r/f=%b%b%b cnt=%0d",
                   t_out, rise, fall, evt_cnt, e[10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; q_in = 1'b0; qb_in = 1'b1; en = 1'b1; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_t_out", t_out, 0);
    check("rst_cnt", evt_cnt, 0);
    check("rst_state", state, 0);
    check("rst_err", err, 0);
    check("rst_sat", sat, 0);

    // Release reset. This edge only primes the detector.
    rst = 1'b1;
    step(0, 1, 0);

    // Basic sequence 0,1,1,0: one rise, then one fall.
    step(0, 1, 0);
    push(1'b1, 8'd1); step(1, 1, 0);
    step(1, 1, 0);
    push(1'b0, 8'd2); step(0, 1, 0);
    check("basic_cnt", evt_cnt, 2);
    check("basic_state", state, 1);
    check("b_cnt2", b_cnt, 2);
    check("b_sat2", b_sat, 0);

    // Saturation of the 2-bit instance.
    push(1'b1, 8'd3); step(1, 1, 0);
    check("b_cnt3", b_cnt, 3);
    check("b_sat3", b_sat, 1);
    push(1'b0, 8'd4); step(0, 1, 0);
    push(1'b1, 8'd5); step(1, 1, 0);
    check("b_cnt5", b_cnt, 3);
    check("b_sat5", b_sat, 1);
    check("cnt5", evt_cnt, 5);
    check("state5", state, 1);

    // Mid-stream reset while a toggle is pending.
    rst = 1'b0;
    step(0, 1, 0);
    check("mrst_t_out", t_out, 0);
    check("mrst_cnt", evt_cnt, 0);
    check("mrst_state", state, 0);
    check("mrst_sat", sat, 0);
    check("mrst_err", err, 0);
    check("mrst_b_sat", b_sat, 0);
    rst = 1'b1;
    step(1, 1, 0);  // q differs from the reset delay value, but not primed
    check("rel_t_out", t_out, 0);
    check("rel_cnt", evt_cnt, 0);
    check("rel_state", state, 0);

    // Timeout: one toggle, then 16 idle edges.
    push(1'b0, 8'd1); step(0, 1, 0);
    check("to_active", state, 1);
    repeat (15) step(0, 1, 0);
    check("to_idle15", state, 1);
    step(0, 1, 0);
    check("to_stall", state, 2);
    push(1'b1, 8'd2); step(1, 1, 0);
    check("to_resume", state, 1);

    // Disabled toggles are ignored and leave no false toggle on re-enable.
    step(0, 0, 0);
    step(1, 0, 0);
    check("en0_cnt", evt_cnt, 2);
    check("en0_state", state, 1);
    step(1, 1, 0);
    check("reen_cnt", evt_cnt, 2);
    check("reen_t_out", t_out, 0);

    // q/qb fault, then clr colliding with a toggle.
    q_in = 1'b1; qb_in = 1'b1; en = 1'b1; clr = 1'b0;
    @(negedge clk);
    check("err_set", err, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    check("err_hold", err, 1);
    step(0, 1, 1);
    check("clr_cnt", evt_cnt, 0);
    check("clr_err", err, 0);
    check("clr_t_out", t_out, 0);
    check("clr_state", state, 0);
    check("clr_b_cnt", b_cnt, 0);
    check("clr_b_sat", b_sat, 0);
    step(0, 1, 0);
    push(1'b1, 8'd1); step(1, 1, 0);
    check("postclr_cnt", evt_cnt, 1);
    check("postclr_state", state, 1);

    step(1, 1, 0);
    step(1, 1, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tff_decoder.md
TFF_DECODER -- requirements
Module: tff_decoder

Interface
REQ-001 The block SHALL take parameter CNT_W, default 8, the event counter width (>=2).
REQ-002 The block SHALL take parameter TIMEOUT, default 16, the idle cycles without a toggle before STALL (>=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port q_in, input, 1, the toggling level from a T flip-flop, synchronous to clk.
REQ-006 The block SHALL have port qb_in, input, 1, the complement of q_in from the same flip-flop.
REQ-007 The block SHALL have port en, input, 1, the decode enable.
REQ-008 The block SHALL have port clr, input, 1, a synchronous clear of the counter, flags and state.
REQ-009 The block SHALL have port t_out, output, 1, the recovered T input as a one-cycle pulse per toggle.
REQ-010 The block SHALL have ports rise and fall, output, 1 each, one-cycle pulses for 0->1 and 1->0 toggles.
REQ-011 The block SHALL have port evt_cnt, output, CNT_W, the saturating count of detected toggles.
REQ-012 The block SHALL have port sat, output, 1, set when evt_cnt has reached all-ones.
REQ-013 The block SHALL have port err, output, 1, a sticky flag: q_in equalled qb_in on some sampled edge.
REQ-014 The block SHALL have port state, output, 2, the FSM state (IDLE=0, ACTIVE=1, STALL=2).

Function
REQ-015 The block SHALL register q_in into q_d on every clk edge, regardless of en and clr.
REQ-016 A toggle SHALL be detected at an edge when en=1, q_in!=q_d and the primed flag is 1.
REQ-017 The primed flag SHALL set on the first edge after reset; no toggle is detected on that edge.
REQ-018 t_out SHALL be 1 for exactly the cycle after a detected-toggle edge; latency is 1 clk from the q_in change.
REQ-019 rise SHALL equal t_out AND q_in(new)=1; fall SHALL equal t_out AND q_in(new)=0; the two SHALL never both be 1.
REQ-020 evt_cnt SHALL increment by 1 per detected toggle and hold at 2^CNT_W-1 without wrapping.
REQ-021 sat SHALL assert on the same edge evt_cnt becomes all-ones.
REQ-022 err SHALL set on any edge with q_in==qb_in, independent of en, and hold until clr or reset.
REQ-023 With en=0, t_out/rise/fall SHALL be 0, evt_cnt and idle timer SHALL hold, and q_d SHALL keep tracking (no false toggle on re-enable).
REQ-024 FSM IDLE->ACTIVE SHALL occur on a detected toggle.
REQ-025 In ACTIVE the idle timer SHALL reset to 0 on each toggle and increment otherwise; at TIMEOUT-1 without a toggle the FSM SHALL go to STALL.
REQ-026 STALL->ACTIVE SHALL occur on a detected toggle, with the timer restarting at 0.
REQ-027 clr=1 SHALL zero evt_cnt, sat, err and the timer, set state to IDLE, and take priority over a simultaneous toggle (toggle not counted, t_out=0).
REQ-028 clr SHALL not clear primed or q_d.

Reset
REQ-029 With rst=0 at an edge: t_out, rise, fall, sat and err SHALL be 0; evt_cnt SHALL be 0; state SHALL be IDLE; timer SHALL be 0; q_d SHALL be 0; primed SHALL be 0.
REQ-030 Reset SHALL override clr and en; mid-stream reset SHALL discard any pending toggle.

Structure
REQ-031 The FSM state encoding constants SHALL live in a shared package, tff_pkg.
REQ-032 Toggle/edge detection (q_d, primed, rise/fall) SHALL be a sub-module toggle_detect; counter, timer and FSM stay in tff_decoder.

Verification
REQ-033 After reset, drive q_in 0,1,1,0 on successive negedges with qb_in=~q_in, en=1 -> one rise and one fall pulse, evt_cnt=2, state=ACTIVE.
REQ-034 CNT_W=2: 5 toggles -> evt_cnt stays 3, sat=1 from the 3rd toggle onward.
REQ-035 Toggle once, then hold q_in for 16 cycles (TIMEOUT=16) -> STALL entered at the 16th idle edge; the next toggle -> ACTIVE.
REQ-036 en=0 while q_in toggles twice, then en=1 -> no pulses, evt_cnt unchanged, no pulse at re-enable.
REQ-037 Drive qb_in=q_in for one cycle -> err=1 and held; clr on the same edge as a toggle -> evt_cnt=0, err=0, t_out=0, state=IDLE.
REQ-038 Assert rst=0 while ACTIVE with evt_cnt=5 -> all outputs reach reset values on that edge; the first edge after release produces no toggle.
